// File: rtl/div_operand_seq.sv
// div_operand_seq: operand front-end for the restoring divider.
// It synchronizes and debounces the "go" button and latches the operands from
// the switches. A divide-by-zero request is rejected. Otherwise the block
// issues a one-cycle start pulse and holds the operands until div_done.
// Optional watchdog: define WATCHDOG_EN to abort a WAIT that lasts too long.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a debounced press
//   CHECK | operands latched, testing divisor for zero
//   START | one-cycle start pulse to the divider
//   WAIT  | divider running, operands frozen until div_done
//   ERR   | last request had divisor 0, waiting for a new press
module div_operand_seq #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_go,
    input  logic [WIDTH-1:0] sw_dividend,
    input  logic [WIDTH-1:0] sw_divisor,
    input  logic             div_done,
    output logic [WIDTH-1:0] dividend,
    output logic [WIDTH-1:0] divisor,
    output logic             start,
    output logic             busy,
    output logic             div_zero,
    output logic             timeout
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic            sync1, btn_s;
    logic [DB_W-1:0] db_cnt;
    logic            btn_db, btn_db_d;
    logic            press;
    logic            latch, set_zero, set_to, wd_expire;

    // two-flop synchronizer on the raw button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn_go;
            btn_s <= sync1;
        end
    end

    // debounce: a level change must hold DEBOUNCE_CYCLES cycles to be accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_d <= 1'b0;
        end else begin
            btn_db_d <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = btn_db & ~btn_db_d;

`ifdef WATCHDOG_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] wd_cnt;
    logic            timeout_r;

    assign wd_expire = (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // watchdog counter: zero outside WAIT, counts each WAIT cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state != WAIT) begin
            wd_cnt <= '0;
        end else if (!wd_expire) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // sticky timeout flag, cleared by the next accepted press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_r <= 1'b0;
        end else if (latch) begin
            timeout_r <= 1'b0;
        end else if (set_to) begin
            timeout_r <= 1'b1;
        end
    end

    assign timeout = timeout_r;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next-state and Moore outputs
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busy      = 1'b0;
        latch     = 1'b0;
        set_zero  = 1'b0;
        set_to    = 1'b0;
        case (state)
            IDLE, ERR: begin
                if (press) begin
                    latch     = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (divisor == '0) begin
                    set_zero  = 1'b1;
                    state_nxt = ERR;
                end else begin
                    state_nxt = START;
                end
            end
            START: begin
                busy      = 1'b1;
                start     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (div_done) begin
                    state_nxt = IDLE;
                end else if (wd_expire) begin
                    set_to    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // operand latch and sticky divide-by-zero flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dividend <= '0;
            divisor  <= '0;
            div_zero <= 1'b0;
        end else if (latch) begin
            dividend <= sw_dividend;
            divisor  <= sw_divisor;
            div_zero <= 1'b0;
        end else if (set_zero) begin
            div_zero <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_operand_seq.sv
// Bench for div_operand_seq. The expected operands of every start pulse go
// into a queue when the press is driven. The negedge monitor logs each
// observed start pulse, and the log is compared in order.
module tb_div_operand_seq;

`ifdef WATCHDOG_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic       clk, rst, btn_go, div_done;
    logic [3:0] sw_dividend, sw_divisor;
    logic [3:0] dividend, divisor;
    logic       start, busy, div_zero, timeout;

    div_operand_seq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .btn_go(btn_go),
        .sw_dividend(sw_dividend), .sw_divisor(sw_divisor),
        .div_done(div_done),
        .dividend(dividend), .divisor(divisor),
        .start(start), .busy(busy), .div_zero(div_zero), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] dvd;
        logic [3:0] dvs;
        logic       exp_zero;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];
    int         start_total = 0;
    int         rd_idx = 0;
    int         checks = 0;
    int         failures = 0;
    int         base;

    // monitor: log operands seen with each start pulse
    always @(negedge clk) begin
        if (start) begin
            obs_q.push_back({dividend, divisor});
            start_total++;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_done();
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
    endtask

    task automatic drain();
        while (rd_idx < obs_q.size()) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_start: got %0h expected none", obs_q[rd_idx]);
            end else begin
                check("start_operands", int'(obs_q[rd_idx]), int'(exp_q.pop_front()));
            end
            rd_idx++;
        end
    endtask

    initial begin
        rst = 1'b0; btn_go = 1'b0; div_done = 1'b0;
        sw_dividend = '0; sw_divisor = '0;
        vecs[0] = '{dvd: 4'd13, dvs: 4'd3, exp_zero: 1'b0};
        vecs[1] = '{dvd: 4'd6,  dvs: 4'd0, exp_zero: 1'b1};
        vecs[2] = '{dvd: 4'd6,  dvs: 4'd5, exp_zero: 1'b0};
        vecs[3] = '{dvd: 4'd0,  dvs: 4'd0, exp_zero: 1'b1};
        vecs[4] = '{dvd: 4'd15, dvs: 4'd1, exp_zero: 1'b0};

        tick(3);
        check("rst_outputs", int'({dividend, divisor, start, busy, div_zero, timeout}), 0);
        rst = 1'b1;
        tick(5);

        // clean press: latch at edge 7, start after edge 8 only
        sw_dividend = 4'd13; sw_divisor = 4'd3;
        exp_q.push_back({4'd13, 4'd3});
        btn_go = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            if (e == 6) check("pre_latch_dividend", int'(dividend), 0);
            if (e == 7) begin
                check("latch_dividend", int'(dividend), 13);
                check("latch_divisor", int'(divisor), 3);
                check("busy_check", int'(busy), 1);
            end
            if (e >= 7) check($sformatf("start_edge%0d", e), int'(start), (e == 8) ? 1 : 0);
        end
        btn_go = 1'b0;
        tick(5);
        check("busy_wait", int'(busy), 1);
        pulse_done();
        check("busy_after_done", int'(busy), 0);
        tick(10);
        drain();

        // asynchronous reset in the middle of a request
        sw_dividend = 4'd9; sw_divisor = 4'd4;
        btn_go = 1'b1;
        tick(7);
        check("busy_before_rst", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_outputs", int'({dividend, divisor, start, busy, div_zero, timeout}), 0);
        btn_go = 1'b0;
        tick(3);
        rst = 1'b1;
        base = start_total;
        tick(25);
        check("no_start_after_rst", start_total - base, 0);
        check("idle_after_rst", int'(busy), 0);

        // bouncing press: one start, 8 edges after the final rise
        sw_dividend = 4'd11; sw_divisor = 4'd2;
        exp_q.push_back({4'd11, 4'd2});
        base = start_total;
        btn_go = 1'b1; tick(2);
        btn_go = 1'b0; tick(2);
        btn_go = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            check($sformatf("bounce_start_e%0d", e), int'(start), (e == 8) ? 1 : 0);
        end
        tick(3);
        btn_go = 1'b0;
        tick(3);
        check("bounce_one_start", start_total - base, 1);
        pulse_done();
        tick(10);
        drain();

        // table of requests, including divide-by-zero and recovery from ERR
        for (int i = 0; i < 5; i++) begin
            sw_dividend = vecs[i].dvd;
            sw_divisor  = vecs[i].dvs;
            if (!vecs[i].exp_zero) exp_q.push_back({vecs[i].dvd, vecs[i].dvs});
            base = start_total;
            btn_go = 1'b1;
            tick(10);
            check($sformatf("vec%0d_div_zero", i), int'(div_zero), int'(vecs[i].exp_zero));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(!vecs[i].exp_zero));
            check($sformatf("vec%0d_dividend", i), int'(dividend), int'(vecs[i].dvd));
            check($sformatf("vec%0d_divisor", i), int'(divisor), int'(vecs[i].dvs));
            check($sformatf("vec%0d_starts", i), start_total - base, int'(!vecs[i].exp_zero));
            if (busy) pulse_done();
            btn_go = 1'b0;
            tick(10);
            drain();
        end

`ifndef WATCHDOG_EN
        // press and switch changes during WAIT are ignored
        sw_dividend = 4'd9; sw_divisor = 4'd2;
        exp_q.push_back({4'd9, 4'd2});
        base = start_total;
        btn_go = 1'b1; tick(10);
        btn_go = 1'b0; tick(10);
        sw_dividend = 4'd1; sw_divisor = 4'd1;
        btn_go = 1'b1; tick(10);
        btn_go = 1'b0; tick(10);
        check("lock_dividend", int'(dividend), 9);
        check("lock_divisor", int'(divisor), 2);
        check("lock_busy", int'(busy), 1);
        pulse_done();
        tick(10);
        check("lock_one_start", start_total - base, 1);
        check("lock_idle", int'(busy), 0);
        drain();

        // press and div_done on the same edge: div_done wins, press is lost
        sw_dividend = 4'd3; sw_divisor = 4'd1;
        exp_q.push_back({4'd3, 4'd1});
        base = start_total;
        btn_go = 1'b1; tick(10);
        btn_go = 1'b0; tick(10);
        btn_go = 1'b1; tick(6);
        div_done = 1'b1; tick(1); div_done = 1'b0;
        check("collide_idle", int'(busy), 0);
        tick(10);
        check("collide_one_start", start_total - base, 1);
        check("collide_still_idle", int'(busy), 0);
        btn_go = 1'b0; tick(10);
        drain();

        // no watchdog: WAIT holds indefinitely, timeout stays 0
        sw_dividend = 4'd8; sw_divisor = 4'd3;
        exp_q.push_back({4'd8, 4'd3});
        btn_go = 1'b1; tick(10);
        btn_go = 1'b0; tick(40);
        check("nowd_busy", int'(busy), 1);
        check("nowd_timeout", int'(timeout), 0);
        pulse_done();
        tick(5);
        drain();
`else
        // watchdog expiry after 8 WAIT cycles
        sw_dividend = 4'd8; sw_divisor = 4'd3;
        exp_q.push_back({4'd8, 4'd3});
        btn_go = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            if (e == 16) begin
                check("wd_busy_last", int'(busy), 1);
                check("wd_timeout_early", int'(timeout), 0);
            end
            if (e == 17) begin
                check("wd_exit_busy", int'(busy), 0);
                check("wd_timeout_set", int'(timeout), 1);
            end
        end
        btn_go = 1'b0; tick(10);
        check("wd_timeout_sticky", int'(timeout), 1);
        drain();

        // div_done on the expiry edge takes priority
        sw_dividend = 4'd8; sw_divisor = 4'd4;
        exp_q.push_back({4'd8, 4'd4});
        btn_go = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            if (e == 7) check("wd_timeout_cleared", int'(timeout), 0);
            if (e == 16) begin
                check("wd2_busy_last", int'(busy), 1);
                div_done = 1'b1;
            end
            if (e == 17) begin
                div_done = 1'b0;
                check("wd2_exit_busy", int'(busy), 0);
                check("wd2_timeout", int'(timeout), 0);
            end
        end
        btn_go = 1'b0; tick(10);
        drain();
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
